// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Holds the edge-mode encoding and the mode qualification function used by every channel.
package edge_det_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    BOTH = 2'd3
  } edge_mode_e;

  // True when a toggle to new_level counts as an event under the given mode.
  function automatic logic edge_qualify(input edge_mode_e mode, input logic new_level);
    logic w_hit;
    w_hit = 1'b0;
    case (mode)
      RISE:    w_hit = new_level;
      FALL:    w_hit = !new_level;
      BOTH:    w_hit = 1'b1;
      default: w_hit = 1'b0;
    endcase
    return w_hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One input channel: synchroniser chain, persistence filter and mode-qualified pulse.
// level and pe update on the same edge; en/mode only gate the pulse, never the level.
module edge_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  edge_mode_e mode,
  input  logic       en,
  output logic       level,
  output logic       pe
);

  localparam int unsigned FCNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FCNT_W-1:0]      r_fcnt;
  logic                   r_level;
  logic                   r_pe;

  logic [FCNT_W-1:0]      w_fcnt_nxt;
  logic                   w_sync;
  logic                   w_differ;
  logic                   w_toggle;
  logic                   w_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig};
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync ^ r_level;
  // The count accepts on the cycle it would reach FILT_CYCLES, so compare against FILT_CYCLES-1.
  assign w_toggle = w_differ && (r_fcnt == FCNT_LAST);
  assign w_event  = w_toggle && en && edge_qualify(mode, !r_level);

  always_comb begin
    w_fcnt_nxt = '0;
    if (w_differ && !w_toggle) begin
      w_fcnt_nxt = r_fcnt + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_level <= 1'b0;
      r_pe    <= 1'b0;
    end else begin
      r_fcnt  <= w_fcnt_nxt;
      r_level <= r_level ^ w_toggle;
      r_pe    <= w_event;
    end
  end

  assign level = r_level;
  assign pe    = r_pe;

endmodule

// File: rtl/edge_detect_array.sv
// N_CH-channel edge detector: per-channel clean pulses plus sticky flags and a
// saturating aggregate event counter for the downstream control logic.
module edge_detect_array
  import edge_det_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sig,
  input  edge_mode_e       mode,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  flag_clr,
  input  logic             cnt_clr,
  output logic [N_CH-1:0]  level,
  output logic [N_CH-1:0]  pe,
  output logic [N_CH-1:0]  flag,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int unsigned POP_W = $clog2(N_CH + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [N_CH-1:0]  w_level;
  logic [N_CH-1:0]  w_pe;
  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [N_CH-1:0]  r_flag;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .sig   (sig[g]),
      .mode  (mode),
      .en    (en[g]),
      .level (w_level[g]),
      .pe    (w_pe[g])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_pop = w_pop + POP_W'(w_pe[i]);
    end
  end

  // A clear in the same cycle as pulses restarts the count from those pulses.
  always_comb begin
    w_base    = cnt_clr ? '0 : SUM_W'(r_cnt);
    w_sum     = w_base + SUM_W'(w_pop);
    w_cnt_nxt = (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
  end

  // Set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= '0;
      r_cnt  <= '0;
    end else begin
      r_flag <= (r_flag & ~flag_clr) | w_pe;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign level   = w_level;
  assign pe      = w_pe;
  assign flag    = r_flag;
  assign evt_cnt = r_cnt;

endmodule

// File: tb/tb_edge_detect_array.sv
// Scoreboard bench for edge_detect_array: stimulus queues expected pulses, a monitor
// checks each pulse's cycle and vector and the flag/count one edge later.
module tb_edge_detect_array;
  import edge_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sig, en, flag_clr;
  logic       cnt_clr;
  edge_mode_e mode;
  logic [7:0] level, pe, flag, evt_cnt;

  logic [7:0] sig_b, en_b, flag_clr_b;
  logic       cnt_clr_b;
  edge_mode_e mode_b;
  logic [7:0] level_b, pe_b, flag_b;
  logic [2:0] evt_cnt_b;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [7:0] pe;
    logic [7:0] flag;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t pend;
  logic chk_pend = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_detect_array u_dut (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .en(en), .flag_clr(flag_clr),
    .cnt_clr(cnt_clr), .level(level), .pe(pe), .flag(flag), .evt_cnt(evt_cnt)
  );

  edge_detect_array #(.CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .sig(sig_b), .mode(mode_b), .en(en_b), .flag_clr(flag_clr_b),
    .cnt_clr(cnt_clr_b), .level(level_b), .pe(pe_b), .flag(flag_b), .evt_cnt(evt_cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [7:0] p, input logic [7:0] f, input logic [7:0] cn);
    exp_t e;
    e.cyc  = c;
    e.pe   = p;
    e.flag = f;
    e.cnt  = cn;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: flags/count one edge after a pulse, then missed or unexpected pulses.
  always @(negedge clk) begin
    if (chk_pend) begin
      check("flag_after_pe", 32'(flag), 32'(pend.flag));
      check("cnt_after_pe", 32'(evt_cnt), 32'(pend.cnt));
      chk_pend = 1'b0;
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL missed_pulse: got none expected pe=0x%0h at cycle %0d", mon_e.pe, mon_e.cyc);
    end
    if (pe != 8'h00) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pe=0x%0h expected none (cycle %0d)", pe, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("pulse_vector", 32'(pe), 32'(mon_e.pe));
        pend     = mon_e;
        chk_pend = 1'b1;
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; sig = '0; mode = RISE; en = '1; flag_clr = '0; cnt_clr = 1'b0;
    sig_b = '0; mode_b = RISE; en_b = '1; flag_clr_b = '0; cnt_clr_b = 1'b0;
    step(3);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle", {level, pe, flag, evt_cnt}, 32'h0);
    end

    // Single rise on channel 0: pulse 6 edges later
    k = cyc; sig[0] = 1'b1; push(k + 6, 8'h01, 8'h01, 8'd1);
    step(5); check("lvl0_before", 32'(level[0]), 32'd0);
    step(1); check("lvl0_after", 32'(level[0]), 32'd1);
    step(6);

    // 3-cycle glitch rejected
    sig[3] = 1'b1; step(3); sig[3] = 1'b0; step(12);
    check("glitch3_level", 32'(level[3]), 32'd0);
    check("glitch3_cnt", 32'(evt_cnt), 32'd1);

    // 4-cycle glitch, RISE: one pulse
    k = cyc; sig[3] = 1'b1; push(k + 6, 8'h08, 8'h09, 8'd2);
    step(4); sig[3] = 1'b0;
    step(5); check("g4_level_hi", 32'(level[3]), 32'd1);
    step(1); check("g4_level_lo", 32'(level[3]), 32'd0);
    step(6);

    // 4-cycle glitch, BOTH: two pulses 4 cycles apart
    mode = BOTH; k = cyc; sig[3] = 1'b1;
    push(k + 6, 8'h08, 8'h09, 8'd3); push(k + 10, 8'h08, 8'h09, 8'd4);
    step(4); sig[3] = 1'b0; step(12);

    // 4-cycle glitch, NONE: level moves, no pulse
    mode = NONE; sig[3] = 1'b1; step(4); sig[3] = 1'b0;
    step(5); check("none_level_hi", 32'(level[3]), 32'd1);
    step(7);
    check("none_cnt", 32'(evt_cnt), 32'd4);
    check("none_flag", 32'(flag), 32'h09);

    // All channels rise together
    mode = RISE; sig = '0; step(10);
    flag_clr = '1; step(1); flag_clr = '0;
    check("flag_cleared", 32'(flag), 32'h00);
    check("cnt_kept", 32'(evt_cnt), 32'd4);
    k = cyc; sig = 8'hFF; push(k + 6, 8'hFF, 8'hFF, 8'd12);
    step(12);

    // flag_clr[2] coincides with the flag set from a new pe[2]; flag[5] does clear
    sig[2] = 1'b0; step(10);
    check("lvl2_fell", 32'(level[2]), 32'd0);
    k = cyc; sig[2] = 1'b1; push(k + 6, 8'h04, 8'hDF, 8'd13);
    step(6); flag_clr = 8'h24; step(1); flag_clr = '0; step(4);

    // en[1]=0: level follows, no pulse
    mode = BOTH; en = 8'hFD; sig[1] = 1'b0;
    step(6); check("en_off_level", 32'(level[1]), 32'd0);
    step(2); check("en_off_cnt", 32'(evt_cnt), 32'd13);

    // Reset mid-filter: pending fall lost; high inputs re-accepted as rises afterwards
    sig[4] = 1'b0; step(3); rst = 1'b1; step(1);
    check("rst_clear", {level, pe, flag, evt_cnt}, 32'h0);
    rst = 1'b0; k = cyc; push(k + 6, 8'hED, 8'hED, 8'd6);
    step(12);

    // Narrow counter: saturation and clear with concurrent pulses
    sig_b = 8'hFF; step(6); check("b_pe_all", 32'(pe_b), 32'hFF);
    step(1); check("b_cnt_sat8", 32'(evt_cnt_b), 32'd7);
    check("b_flag_all", 32'(flag_b), 32'hFF);
    sig_b[0] = 1'b0; step(10); sig_b[0] = 1'b1;
    step(6); check("b_pe_9th", 32'(pe_b), 32'h01);
    step(1); check("b_cnt_sat9", 32'(evt_cnt_b), 32'd7);
    sig_b[2:1] = 2'b00; step(10);
    check("b_cnt_hold", 32'(evt_cnt_b), 32'd7);
    sig_b[2:1] = 2'b11; step(6); check("b_pe_pair", 32'(pe_b), 32'h06);
    cnt_clr_b = 1'b1; step(1); cnt_clr_b = 1'b0;
    check("b_cnt_clr", 32'(evt_cnt_b), 32'd2);

    step(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
